data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 48, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 64, memory data width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid[i], i=0..1  input  1  requester i presents an access.
REQ-006 SHALL have ports req_write[i]  input  1  1 = store, 0 = load.
REQ-007 SHALL have ports req_addr[i]  input  ADDR_W  access address.
REQ-008 SHALL have ports req_wdata[i]  input  DATA_W  store data.
REQ-009 SHALL have ports req_ready[i]  output  1  request i accepted this cycle.
REQ-010 SHALL have ports resp_valid[i]  output  1  one-cycle completion pulse to requester i.
REQ-011 SHALL have ports resp_rdata[i]  output  DATA_W  load data, held until next response to i.
REQ-012 SHALL have port memWrite  output  1  write strobe to data memory.
REQ-013 SHALL have port memRead  output  1  read enable to data memory.
REQ-014 SHALL have port address  output  ADDR_W  data memory address.
REQ-015 SHALL have port writeData  output  DATA_W  data memory write data.
REQ-016 SHALL have port readData  input  DATA_W  data memory read data, valid combinationally while memRead=1.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESPOND.
REQ-018 IDLE: any req_valid -> assert req_ready to exactly one winner, latch winner's write/addr/wdata and winner id, go to ACCESS.
REQ-019 Handshake: transfer occurs when req_valid[i] & req_ready[i]; req_ready SHALL be combinational from state IDLE and arbitration, never high outside IDLE.
REQ-020 Arbitration: round-robin; on simultaneous requests winner is the port not granted last; single requester wins regardless of pointer.
REQ-021 Last-grant pointer SHALL update only on a transfer.
REQ-022 ACCESS (exactly one cycle): drive address/writeData from latch; memWrite=1 for store, memRead=1 for load, never both; capture readData into resp_rdata[id] for loads; go to RESPOND.
REQ-023 RESPOND (exactly one cycle): resp_valid[id]=1, other resp_valid=0; go to IDLE.
REQ-024 Latency: transfer in cycle N -> memory strobe in N+1 -> resp_valid in N+2; back-to-back grants no closer than 3 cycles.
REQ-025 Outside ACCESS, memWrite=memRead=0; address/writeData SHALL hold last latched values.
REQ-026 Stores SHALL leave resp_rdata[id] unchanged.
REQ-027 Requester deasserting req_valid before grant SHALL be ignored; no request is lost once transferred.
REQ-028 Request arriving in ACCESS/RESPOND waits; it is granted in the next IDLE cycle.

Reset
REQ-029 On reset: state IDLE, pointer favours port 0, req_ready/resp_valid/memWrite/memRead = 0, address/writeData/resp_rdata = 0.
REQ-030 Reset mid-operation SHALL abort immediately: any in-flight store strobe drops same cycle, no resp_valid issued.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (2-bit enum IDLE=0, ACCESS=1, RESPOND=2) and ADDR_W/DATA_W defaults.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output grant[1:0]).
REQ-033 Data memory SHALL be instantiated outside this block.

Verification
REQ-034 Single store: port0 store addr 5 data 0x1 -> memWrite=1 with address=5, writeData=1 at N+1; resp_valid[0] at N+2.
REQ-035 Load-back: port1 load addr 5 after REQ-034 -> memRead=1 at N+1, resp_rdata[1]=0x1 with resp_valid[1] at N+2.
REQ-036 Contention: both ports request continuously from reset -> grants alternate 0,1,0,1, each 3 cycles apart.
REQ-037 Sixteen stores addr i*5 data i+1 (i=0..15) via port0, then sixteen loads via port1 -> every load returns i+1.
REQ-038 Reset asserted during ACCESS of a store -> memWrite falls immediately, no resp_valid, state IDLE, next request granted to port 0.
REQ-039 Request withdrawn while arbiter in RESPOND -> never granted, no memory strobe.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding and
// default address/data widths.
package data_memory_arbiter_pkg;
    localparam int ADDR_W_DEF = 48;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;
endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and a tie goes to
// the port that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = req;
        if (&req) grant = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/data_memory_arbiter.sv
// Serialises two load/store requesters onto one data memory port.
// Each access takes three cycles: grant (IDLE), strobe (ACCESS), complete (RESPOND).
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             resp_valid,
    output logic [1:0][DATA_W-1:0] resp_rdata,
    output logic                   memWrite,
    output logic                   memRead,
    output logic [ADDR_W-1:0]      address,
    output logic [DATA_W-1:0]      writeData,
    input  logic [DATA_W-1:0]      readData
);
    state_t     state;
    logic       last;
    logic       id;
    logic       op_write;
    logic [1:0] grant;
    logic       transfer;
    logic       win;

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .last  (last),
        .grant (grant)
    );

    // Outputs are also gated by reset so an in-flight strobe drops the
    // moment reset rises, independent of the flop update.
    assign req_ready  = (state == IDLE && !reset) ? grant : 2'b00;
    assign transfer   = |(req_valid & req_ready);
    assign win        = grant[1];
    assign memWrite   = (state == ACCESS) && op_write && !reset;
    assign memRead    = (state == ACCESS) && !op_write && !reset;
    assign resp_valid = (state == RESPOND && !reset) ? (id ? 2'b10 : 2'b01) : 2'b00;

    // last=1 after reset so port 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            id         <= 1'b0;
            op_write   <= 1'b0;
            address    <= '0;
            writeData  <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state     <= ACCESS;
                        last      <= win;
                        id        <= win;
                        op_write  <= req_write[win];
                        address   <= req_addr[win];
                        writeData <= req_wdata[win];
                    end
                end
                ACCESS: begin
                    if (!op_write) resp_rdata[id] <= readData;
                    state <= RESPOND;
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomised and directed bench for data_memory_arbiter against a
// transaction-timing reference model with its own memory image.
module tb_data_memory_arbiter;
    localparam int AW = 48;
    localparam int DW = 64;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_write = '0;
    logic [1:0][AW-1:0] req_addr  = '0;
    logic [1:0][DW-1:0] req_wdata = '0;
    logic [1:0]         req_ready;
    logic [1:0]         resp_valid;
    logic [1:0][DW-1:0] resp_rdata;
    logic               memWrite;
    logic               memRead;
    logic [AW-1:0]      address;
    logic [DW-1:0]      writeData;
    logic [DW-1:0]      readData;

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData)
    );

    always #5 clock = ~clock;

    // External data memory (256 words, low address bits).
    logic [DW-1:0] mem [256];
    logic          mem_init = 1'b1;
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (memWrite) begin
            mem[address[7:0]] <= writeData;
        end
    end
    assign readData = memRead ? mem[address[7:0]] : '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] exp_rdata [2];
    int            c = 0;
    bit            infl = 0;
    int            g_cyc = 0;
    int            g_id = 0;
    bit            g_wr = 0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_data = '0;
    bit            m_last = 1;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_data = '0;
    int            gq_port[$];
    int            gq_cyc[$];

    // Staged stimulus for the next cycle
    logic [1:0]    s_v = '0;
    logic [1:0]    s_w = '0;
    logic [AW-1:0] s_a [2];
    logic [DW-1:0] s_d [2];

    task automatic model_reset();
        infl   = 0;
        m_last = 1;
        h_addr = '0;
        h_data = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset     = 1'b1;
        req_valid = 2'b11;
        model_reset();
        @(negedge clock);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_memWrite", 64'(memWrite), 64'd0);
        chk("rst_memRead", 64'(memRead), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_writeData", writeData, 64'd0);
        chk("rst_rdata0", resp_rdata[0], 64'd0);
        chk("rst_rdata1", resp_rdata[1], 64'd0);
        @(posedge clock); #2;
        reset     = 1'b0;
        mem_init  = 1'b0;
        req_valid = '0;
        s_v       = '0;
    endtask

    task automatic step();
        bit         busy, acc, rsp;
        logic [1:0] er;
        logic [1:0] ev;
        int         win;
        @(posedge clock); #1;
        req_valid = s_v;
        req_write = s_w;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = s_a[i];
            req_wdata[i] = s_d[i];
        end
        c++;
        busy = infl && (c <= g_cyc + 2);
        acc  = infl && (c == g_cyc + 1);
        rsp  = infl && (c == g_cyc + 2);
        if (rsp && !g_wr) exp_rdata[g_id] = exp_mem[g_addr[7:0]];
        er  = 2'b00;
        win = -1;
        if (!busy && s_v != 2'b00) begin
            if (s_v == 2'b11) win = m_last ? 0 : 1;
            else              win = s_v[1] ? 1 : 0;
            er[win] = 1'b1;
        end
        ev = rsp ? ((g_id == 1) ? 2'b10 : 2'b01) : 2'b00;
        @(negedge clock);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("memWrite", 64'(memWrite), 64'(acc && g_wr));
        chk("memRead", 64'(memRead), 64'(acc && !g_wr));
        chk("address", 64'(address), 64'(h_addr));
        chk("writeData", writeData, h_data);
        chk("resp_valid", 64'(resp_valid), 64'(ev));
        chk("resp_rdata0", resp_rdata[0], exp_rdata[0]);
        chk("resp_rdata1", resp_rdata[1], exp_rdata[1]);
        if (req_ready != 2'b00) begin
            gq_port.push_back(req_ready[1] ? 1 : 0);
            gq_cyc.push_back(c);
        end
        if (acc && g_wr) exp_mem[g_addr[7:0]] = g_data;
        if (rsp) infl = 0;
        if (win >= 0) begin
            infl   = 1;
            g_cyc  = c;
            g_id   = win;
            g_wr   = s_w[win];
            g_addr = s_a[win];
            g_data = s_d[win];
            m_last = (win == 1);
            h_addr = g_addr;
            h_data = g_data;
        end
    endtask

    task automatic xfer(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_v = '0;
        s_v[p] = 1'b1;
        s_w[p] = w;
        s_a[p] = a;
        s_d[p] = d;
        step(); step(); step();
        s_v = '0;
    endtask

    initial begin
        int b;
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        s_a[0] = '0; s_a[1] = '0; s_d[0] = '0; s_d[1] = '0;
        do_reset();

        // Single store then load-back on the other port
        xfer(0, 1'b1, 48'd5, 64'h1);
        xfer(1, 1'b0, 48'd5, 64'h0);
        chk("loadback", resp_rdata[1], 64'h1);

        // Sixteen stores via port 0, sixteen loads via port 1
        for (int i = 0; i < 16; i++) xfer(0, 1'b1, 48'(i * 5), 64'(i + 1));
        for (int i = 0; i < 16; i++) begin
            xfer(1, 1'b0, 48'(i * 5), 64'hdead);
            chk("seq_load", resp_rdata[1], 64'(i + 1));
        end

        // Continuous contention from reset
        do_reset();
        b = gq_port.size();
        s_v = 2'b11; s_w = 2'b11;
        s_a[0] = 48'd100; s_a[1] = 48'd101;
        s_d[0] = 64'haaaa; s_d[1] = 64'hbbbb;
        for (int i = 0; i < 13; i++) step();
        s_v = '0;
        chk("cont_count", 64'(gq_port.size() - b), 64'd5);
        for (int k = 0; k < 5 && b + k < gq_port.size(); k++) begin
            chk("cont_port", 64'(gq_port[b+k]), 64'(k % 2));
            if (k > 0) chk("cont_gap", 64'(gq_cyc[b+k] - gq_cyc[b+k-1]), 64'd3);
        end
        step(); step();

        // Reset during the ACCESS cycle of a store
        s_v = 2'b01; s_w = 2'b01; s_a[0] = 48'd9; s_d[0] = 64'hcafe;
        step();
        @(posedge clock); #1;
        req_valid = '0; s_v = '0;
        chk("abort_pre_memWrite", 64'(memWrite), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_memWrite", 64'(memWrite), 64'd0);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        model_reset();
        @(negedge clock);
        chk("abort_resp_valid_neg", 64'(resp_valid), 64'd0);
        @(posedge clock); #2 reset = 1'b0;
        s_v = 2'b11; s_w = 2'b00; s_a[0] = 48'd9; s_a[1] = 48'd9;
        step();
        s_v = 2'b00;
        chk("post_abort_port", 64'(gq_port[$]), 64'd0);
        step(); step();
        chk("abort_no_write", resp_rdata[0], 64'd0);

        // Port 1 request withdrawn while busy is never served
        b = gq_port.size();
        s_v = 2'b01; s_w = 2'b01; s_a[0] = 48'd20; s_d[0] = 64'h77;
        step();
        s_v = 2'b10; s_w = 2'b11; s_a[1] = 48'd21; s_d[1] = 64'h88;
        step(); step();
        s_v = 2'b00;
        step(); step(); step();
        chk("withdraw_grants", 64'(gq_port.size() - b), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            s_v = 2'($urandom_range(0, 3));
            s_w = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                s_a[p] = 48'($urandom_range(0, 255));
                s_d[p] = {$urandom, $urandom};
            end
            step();
        end
        s_v = '0;
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
